// File: rtl/dc_deger_pkg.sv
// Shared types and helpers for the JPEG DC value decoder and its EXTEND stage.
// The EXTEND offset helper is sized for the widest category a 4-bit field can carry.
package dc_deger_pkg;

  localparam int KATEGORI_GENISLIK = 4;
  localparam int OFSET_GENISLIK    = 16;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    TOPLA = 2'd1,
    CIKIS = 2'd2
  } durum_e;

  // 2^cat - 1: what a negative magnitude is shifted down by.
  function automatic logic [OFSET_GENISLIK-1:0] genislet_ofset(
    input logic [KATEGORI_GENISLIK-1:0] kat
  );
    genislet_ofset = (OFSET_GENISLIK'(1) << kat) - OFSET_GENISLIK'(1);
  endfunction

endpackage

// File: rtl/dc_deger_cozucu_genislet.sv
// Combinational JPEG EXTEND: turns cat raw magnitude bits into a signed difference.
// Shared with the AC path, so it does not assume anything about the caller's FSM.
module dc_genislet
  import dc_deger_pkg::*;
#(
  parameter int uzunluk = 11
) (
  input  logic [uzunluk-1:0]           ham_i,
  input  logic [KATEGORI_GENISLIK-1:0] kat_i,
  output logic signed [uzunluk:0]      fark_o
);

  logic                      ust_bit;
  logic [OFSET_GENISLIK-1:0] ofset;
  logic [uzunluk:0]          ham_genis;

  always_comb begin
    ust_bit = 1'b0;
    for (int i = 0; i < uzunluk; i++) begin
      if (int'(kat_i) == i + 1) begin
        ust_bit = ham_i[i];
      end
    end
  end

  assign ofset     = genislet_ofset(kat_i);
  assign ham_genis = {1'b0, ham_i};

  always_comb begin
    fark_o = '0;
    if (kat_i != '0) begin
      // A leading zero marks a negative value in the JPEG magnitude code.
      if (ust_bit) begin
        fark_o = $signed(ham_genis);
      end else begin
        fark_o = $signed(ham_genis - ofset[uzunluk:0]);
      end
    end
  end

endmodule

// File: rtl/dc_deger_cozucu.sv
// Bit-serial JPEG DC decoder: category, then MSB-first magnitude bits, then
// EXTEND and accumulation onto the running DC predictor.
module dc_deger_cozucu
  import dc_deger_pkg::*;
#(
  parameter int uzunluk = 11
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [KATEGORI_GENISLIK-1:0] kategori_i,
  input  logic                         kategori_gecerli_i,
  output logic                         kategori_hazir_o,
  input  logic                         bit_i,
  input  logic                         bit_gecerli_i,
  output logic                         bit_hazir_o,
  output logic signed [uzunluk:0]      fark_o,
  output logic signed [uzunluk:0]      dc_o,
  output logic                         cikis_gecerli_o,
  input  logic                         cikis_hazir_i,
  input  logic                         tahmin_sifirla_i,
  output logic                         hata_o
);

  durum_e                         durum_q, durum_d;
  logic [KATEGORI_GENISLIK-1:0]   kat_q, kat_d;
  logic [uzunluk-1:0]             kaydir_q, kaydir_d;
  logic [KATEGORI_GENISLIK-1:0]   sayac_q, sayac_d;
  logic signed [uzunluk:0]        tahmin_q, tahmin_d;
  logic signed [uzunluk:0]        fark_q, fark_d;
  logic                           hata_q, hata_d;

  logic                           kat_aktar;
  logic                           bit_aktar;
  logic                           cikis_aktar;
  logic [uzunluk:0]               kaydir_genis;
  logic [uzunluk-1:0]             kaydir_yeni;
  logic [KATEGORI_GENISLIK-1:0]   sayac_yeni;
  logic signed [uzunluk:0]        genis_fark;

  // The incoming bit is folded in before EXTEND so the last bit needs no extra cycle.
  assign kaydir_genis = {kaydir_q, bit_i};
  assign kaydir_yeni  = kaydir_genis[uzunluk-1:0];
  assign sayac_yeni   = sayac_q + KATEGORI_GENISLIK'(1);

  dc_genislet #(
    .uzunluk (uzunluk)
  ) u_genislet (
    .ham_i  (kaydir_yeni),
    .kat_i  (kat_q),
    .fark_o (genis_fark)
  );

  always_comb begin
    kategori_hazir_o = en_i && (durum_q == BOSTA);
    bit_hazir_o      = en_i && (durum_q == TOPLA);
    cikis_gecerli_o  = (durum_q == CIKIS);
    fark_o           = fark_q;
    dc_o             = tahmin_q + fark_q;
    hata_o           = hata_q;
  end

  assign kat_aktar   = kategori_gecerli_i && kategori_hazir_o;
  assign bit_aktar   = bit_gecerli_i && bit_hazir_o;
  assign cikis_aktar = en_i && cikis_hazir_i && cikis_gecerli_o;

  always_comb begin
    durum_d  = durum_q;
    kat_d    = kat_q;
    kaydir_d = kaydir_q;
    sayac_d  = sayac_q;
    tahmin_d = tahmin_q;
    fark_d   = fark_q;
    hata_d   = hata_q;
    if (en_i) begin
      hata_d = 1'b0;
      unique case (durum_q)
        BOSTA: begin
          if (kat_aktar) begin
            kat_d    = kategori_i;
            kaydir_d = '0;
            sayac_d  = '0;
            if (kategori_i == '0) begin
              fark_d  = '0;
              durum_d = CIKIS;
            end else if (int'(kategori_i) > uzunluk) begin
              hata_d = 1'b1;
            end else begin
              durum_d = TOPLA;
            end
          end
        end
        TOPLA: begin
          if (bit_aktar) begin
            kaydir_d = kaydir_yeni;
            sayac_d  = sayac_yeni;
            if (sayac_yeni == kat_q) begin
              fark_d  = genis_fark;
              durum_d = CIKIS;
            end
          end
        end
        CIKIS: begin
          if (cikis_aktar) begin
            tahmin_d = dc_o;
            durum_d  = BOSTA;
          end
        end
        default: durum_d = BOSTA;
      endcase
      // A scan restart overrides any predictor update from the same edge.
      if (tahmin_sifirla_i) begin
        tahmin_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      durum_q  <= BOSTA;
      kat_q    <= '0;
      kaydir_q <= '0;
      sayac_q  <= '0;
      tahmin_q <= '0;
      fark_q   <= '0;
      hata_q   <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      kat_q    <= kat_d;
      kaydir_q <= kaydir_d;
      sayac_q  <= sayac_d;
      tahmin_q <= tahmin_d;
      fark_q   <= fark_d;
      hata_q   <= hata_d;
    end
  end

endmodule

// File: tb/tb_dc_deger_cozucu.sv
// Directed plus randomized check of dc_deger_cozucu against an arithmetic model
// of JPEG EXTEND and a 12-bit wrapping DC predictor.
module tb_dc_deger_cozucu;

  localparam int UZ = 11;
  localparam int G  = UZ + 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [3:0]       kategori;
  logic             kategori_gecerli;
  logic             kategori_hazir;
  logic             bit_v;
  logic             bit_gecerli;
  logic             bit_hazir;
  logic signed [G-1:0] fark;
  logic signed [G-1:0] dc;
  logic             cikis_gecerli;
  logic             cikis_hazir;
  logic             tahmin_sifirla;
  logic             hata;

  dc_deger_cozucu #(.uzunluk(UZ)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .en_i               (en),
    .kategori_i         (kategori),
    .kategori_gecerli_i (kategori_gecerli),
    .kategori_hazir_o   (kategori_hazir),
    .bit_i              (bit_v),
    .bit_gecerli_i      (bit_gecerli),
    .bit_hazir_o        (bit_hazir),
    .fark_o             (fark),
    .dc_o               (dc),
    .cikis_gecerli_o    (cikis_gecerli),
    .cikis_hazir_i      (cikis_hazir),
    .tahmin_sifirla_i   (tahmin_sifirla),
    .hata_o             (hata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pred     = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_fark(input int cat, input int raw);
    if (cat == 0) return 0;
    if (raw >= (1 << (cat - 1))) return raw;
    return raw - ((1 << cat) - 1);
  endfunction

  function automatic int sar(input int v);
    int m;
    m = v & ((1 << G) - 1);
    if (m >= (1 << (G - 1))) m -= (1 << G);
    return m;
  endfunction

  task automatic txn(input int cat, input int raw, input int stall, input bit clr);
    int fark_e;
    int dc_e;
    fark_e = model_fark(cat, raw);
    dc_e   = sar(pred + fark_e);
    chk("kat_hazir", kategori_hazir, 1);
    kategori = 4'(cat);
    kategori_gecerli = 1'b1;
    tick();
    kategori_gecerli = 1'b0;
    for (int i = cat - 1; i >= 0; i--) begin
      if ($urandom_range(0, 3) == 0) begin
        bit_gecerli = 1'b0;
        tick();
        chk("bekleme_gecerli", cikis_gecerli, 0);
      end
      chk("bit_hazir", bit_hazir, 1);
      chk("ara_gecerli", cikis_gecerli, 0);
      chk("ara_kat_hazir", kategori_hazir, 0);
      bit_v = 1'((raw >> i) & 1);
      bit_gecerli = 1'b1;
      kategori_gecerli = 1'($urandom_range(0, 1));
      kategori = 4'($urandom_range(0, 15));
      tick();
      bit_gecerli = 1'b0;
      kategori_gecerli = 1'b0;
    end
    chk("cikis_gecerli", cikis_gecerli, 1);
    chk("fark", fark, fark_e);
    chk("dc", dc, dc_e);
    chk("hata_yok", hata, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("durak_gecerli", cikis_gecerli, 1);
      chk("durak_fark", fark, fark_e);
      chk("durak_dc", dc, dc_e);
      chk("durak_kat_hazir", kategori_hazir, 0);
    end
    cikis_hazir = 1'b1;
    tahmin_sifirla = clr;
    tick();
    cikis_hazir = 1'b0;
    tahmin_sifirla = 1'b0;
    pred = clr ? 0 : dc_e;
    chk("sonra_bosta", kategori_hazir, 1);
    chk("sonra_gecerli", cikis_gecerli, 0);
    $display("txn cat=%0d raw=%0d stall=%0d clr=%0d fark=%0d dc=%0d exp_fark=%0d exp_dc=%0d",
             cat, raw, stall, clr, fark, dc, fark_e, dc_e);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    kategori = '0;
    kategori_gecerli = 1'b0;
    bit_v = 1'b0;
    bit_gecerli = 1'b0;
    cikis_hazir = 1'b0;
    tahmin_sifirla = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_fark", fark, 0);
    chk("rst_dc", dc, 0);
    chk("rst_gecerli", cikis_gecerli, 0);
    chk("rst_bit_hazir", bit_hazir, 0);
    chk("rst_hata", hata, 0);
    chk("rst_kat_hazir", kategori_hazir, 1);

    // Clock enable low: no readies, category is not taken.
    en = 1'b0;
    #1;
    chk("en0_kat_hazir", kategori_hazir, 0);
    kategori = 4'd3;
    kategori_gecerli = 1'b1;
    tick();
    kategori_gecerli = 1'b0;
    chk("en0_bit_hazir", bit_hazir, 0);
    en = 1'b1;
    #1;
    chk("en1_kat_hazir", kategori_hazir, 1);

    txn(3, 5, 0, 1'b0);      // +5, dc 5
    txn(3, 2, 0, 1'b0);      // -5, dc 0
    txn(6, 1, 0, 1'b0);      // -62
    txn(0, 0, 4, 1'b1);      // zero category, backpressure, then clear
    txn(3, 5, 0, 1'b1);      // dc 5 with coincident clear
    txn(1, 1, 0, 1'b0);      // dc 1
    txn(11, 2046, 0, 1'b0);  // dc 2047
    txn(1, 1, 0, 1'b0);      // wraps to -2048

    // Oversized categories flag an error and stay idle.
    for (int k = 12; k <= 15; k += 3) begin
      kategori = 4'(k);
      kategori_gecerli = 1'b1;
      tick();
      kategori_gecerli = 1'b0;
      chk("hata_darbe", hata, 1);
      chk("hata_kat_hazir", kategori_hazir, 1);
      chk("hata_gecerli", cikis_gecerli, 0);
      tick();
      chk("hata_bitti", hata, 0);
      chk("hata_sonra_gecerli", cikis_gecerli, 0);
      $display("txn hata cat=%0d", k);
    end

    // Reset in the middle of collecting bits discards the value.
    kategori = 4'd5;
    kategori_gecerli = 1'b1;
    tick();
    kategori_gecerli = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bit_v = 1'b1;
      bit_gecerli = 1'b1;
      tick();
    end
    bit_gecerli = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pred = 0;
    chk("mrst_gecerli", cikis_gecerli, 0);
    chk("mrst_kat_hazir", kategori_hazir, 1);
    chk("mrst_bit_hazir", bit_hazir, 0);
    chk("mrst_dc", dc, 0);
    $display("txn ara_reset");

    for (int n = 0; n < 40; n++) begin
      int c;
      int r;
      c = $urandom_range(0, UZ);
      r = (c == 0) ? 0 : $urandom_range(0, (1 << c) - 1);
      txn(c, r, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_deger_cozucu.md
# dc_deger_cozucu

Bit-serial JPEG DC coefficient decoder, the inverse of the DC category/value encoder. It accepts a 4-bit size category, then shifts in exactly that many magnitude bits MSB-first. It applies the JPEG EXTEND rule to recover the signed DC difference and adds it to a running DC predictor. It sits between the entropy (Huffman) decoder, which supplies the category and raw bits, and the dequantiser, which consumes the reconstructed DC value.

## Interface
Parameters:
- `uzunluk`, default 11: maximum supported category, which is also the magnitude bit width. Legal range is 1..15. G = `uzunluk`+1 is the signed output width.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `en_i` in 1: clock enable. When 0, all state and outputs hold, and neither ready output asserts.
- `kategori_i` in 4: size category of the next DC difference.
- `kategori_gecerli_i` in 1: `kategori_i` valid.
- `kategori_hazir_o` out 1: the block can accept a category.
- `bit_i` in 1: serial magnitude bit, MSB first.
- `bit_gecerli_i` in 1: `bit_i` valid.
- `bit_hazir_o` out 1: the block can accept a bit.
- `fark_o` out G: signed DC difference.
- `dc_o` out G: signed reconstructed DC, equal to predictor + difference.
- `cikis_gecerli_o` out 1: `fark_o`/`dc_o` valid.
- `cikis_hazir_i` in 1: the consumer accepts the output.
- `tahmin_sifirla_i` in 1: clear the predictor (start of scan or restart marker).
- `hata_o` out 1: one-cycle pulse when the category exceeds `uzunluk`.

## Operation
- Handshakes are valid/ready. A transfer occurs on a rising edge where valid, ready and `en_i` are all 1.
- States:
  - BOSTA: `kategori_hazir_o`=1. On a category transfer, latch cat and clear the shift register and bit counter.
    - cat=0: go to CIKIS with difference 0.
    - cat>`uzunluk`: pulse `hata_o` and stay in BOSTA.
    - Otherwise: go to TOPLA.
  - TOPLA: `bit_hazir_o`=1. Each bit transfer shifts left, inserting `bit_i`, and increments the counter. When the counter reaches cat, go to CIKIS.
  - CIKIS: `cikis_gecerli_o`=1 and the outputs are stable. On an output transfer, predictor ← `dc_o` and return to BOSTA.
- EXTEND rule, with raw = the cat received bits as an unsigned value:
  - If raw[cat-1]=1: difference = +raw.
  - Otherwise: difference = raw − (2^cat − 1).
  - cat=0 gives difference 0.
  - The difference is computed in G bits.
- `dc_o` = predictor + `fark_o`, modulo 2^G in two's complement. Wrap-around is silent, with no saturation.
- `tahmin_sifirla_i` clears the predictor to 0 on any enabled edge.
  - When it coincides with an output transfer, the clear wins and the predictor becomes 0.
  - `dc_o` shown in CIKIS always uses the predictor value at that moment.
- The category and bit inputs are ignored outside their accepting states.

## Timing
- Reset (`rst_ni`=0 at an edge):
  - State goes to BOSTA.
  - Predictor, shift register, counter, `fark_o`, `dc_o` and `hata_o` go to 0.
  - `cikis_gecerli_o`=0 and `bit_hazir_o`=0.
  - `kategori_hazir_o`=1 from the first cycle after reset (while `en_i`=1).
  - Reset mid-TOPLA or in CIKIS discards the pending value.
- Latency:
  - cat=0: `cikis_gecerli_o` asserts in the cycle after the category transfer.
  - cat=N≥1: `cikis_gecerli_o` asserts in the cycle after the Nth bit transfer.
  - With no stalls, minimum throughput is one value per N+2 cycles.
- `hata_o` is high for exactly the one cycle after the offending category transfer.
- There is no overlap: `kategori_hazir_o` is 0 in TOPLA and CIKIS.

## Structure
- Shared package `dc_deger_pkg`:
  - state enum {BOSTA, TOPLA, CIKIS}.
  - constant `KATEGORI_GENISLIK`=4.
  - a function computing the EXTEND offset 2^cat−1.
- One combinational sub-module, `dc_genislet`. Inputs: raw, cat. Output: signed G-bit difference. It is reusable by the AC path.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles → all outputs are 0 and `kategori_hazir_o`=1 after release.
- Positive value: `uzunluk`=11, cat=3, bits 1,0,1 → `fark_o`=+5 and `dc_o`=5 one cycle after the third bit.
- Negative value: then cat=3, bits 0,1,0 → `fark_o`=−5 and `dc_o`=0. Also with `uzunluk`=6, cat=6, bits 000001 → `fark_o`=−62.
- Zero category and backpressure:
  - cat=0 → `fark_o`=0 one cycle later.
  - Hold `cikis_hazir_i`=0 for 4 cycles → outputs stable, `kategori_hazir_o`=0, predictor unchanged.
- Predictor clear:
  - `tahmin_sifirla_i` coinciding with the output transfer of `dc_o`=5 → the next cat=1, bit 1 gives `dc_o`=1.
  - Sum wrap at G=12: predictor 2047 + difference 1 → `dc_o` = −2048.
- Error and mid-operation reset:
  - cat=12 with `uzunluk`=11 → `hata_o` is a single-cycle pulse, there is no output, and the block stays in BOSTA.
  - `rst_ni`=0 after 2 of 5 bits → no output and back to BOSTA.
